// File: rtl/sobel_mdc_engine_ctrl.sv
// Engine-side controller for the sobel MDC HWPE: launches the kernel, counts
// out_pel beats against a per-job limit and reports job completion.
module sobel_mdc_engine_ctrl #(
  parameter int unsigned CNT_LEN = 1024,
  parameter int unsigned CW      = $clog2(CNT_LEN) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          enable_i,
  input  logic          start_i,
  input  logic [CW-1:0] cnt_limit_i,
  input  logic          out_valid_i,
  input  logic          out_ready_i,
  output logic          kernel_start_o,
  input  logic          kernel_ready_i,
  input  logic          kernel_done_i,
  input  logic          kernel_idle_i,
  output logic [CW-1:0] cnt_out_o,
  output logic          done_o,
  output logic          ready_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [CW-1:0] lim_r;
  logic          done_seen_r;

  logic          beat_s;
  logic          accept_s;
  logic          done_ok_s;
  logic [CW-1:0] cnt_nxt_s;

  // Beat qualification and saturating next count (cnt never exceeds lim).
  always_comb begin
    beat_s    = out_valid_i & out_ready_i & enable_i;
    accept_s  = start_i & enable_i & kernel_idle_i;
    done_ok_s = done_seen_r | kernel_done_i;
    if (beat_s && (cnt_r != lim_r)) begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Job FSM with registered handshake and status outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r        <= IDLE;
      cnt_r          <= CNT_ZERO;
      lim_r          <= CNT_ZERO;
      done_seen_r    <= 1'b0;
      kernel_start_o <= 1'b0;
      done_o         <= 1'b0;
      ready_o        <= 1'b1;
    end else if (clear_i) begin
      state_r        <= IDLE;
      cnt_r          <= CNT_ZERO;
      lim_r          <= CNT_ZERO;
      done_seen_r    <= 1'b0;
      kernel_start_o <= 1'b0;
      done_o         <= 1'b0;
      ready_o        <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            lim_r       <= cnt_limit_i;
            cnt_r       <= CNT_ZERO;
            done_seen_r <= 1'b0;
            ready_o     <= 1'b0;
            // An empty job completes without ever touching the kernel.
            if (cnt_limit_i == CNT_ZERO) begin
              state_r <= DONE;
              done_o  <= 1'b1;
            end else begin
              state_r        <= LAUNCH;
              kernel_start_o <= 1'b1;
            end
          end
        end
        LAUNCH: begin
          if (kernel_ready_i) begin
            state_r        <= RUN;
            kernel_start_o <= 1'b0;
          end
        end
        RUN: begin
          cnt_r <= cnt_nxt_s;
          if (kernel_done_i) begin
            done_seen_r <= 1'b1;
          end
          if ((cnt_nxt_s == lim_r) && done_ok_s) begin
            state_r <= DONE;
            done_o  <= 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          done_o  <= 1'b0;
          ready_o <= 1'b1;
        end
        default: begin
          state_r        <= IDLE;
          kernel_start_o <= 1'b0;
          done_o         <= 1'b0;
          ready_o        <= 1'b1;
        end
      endcase
    end
  end

  assign cnt_out_o = cnt_r;

endmodule
